// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            mfhi,
    input  logic            mflo,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] rdata
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic                done_q, done_d;

    logic                is_div, is_signed;
    logic [XLEN-1:0]     abs_a, abs_b, quo, rem;
    logic [XLEN:0]       mul_sum, div_rem_sh, div_diff;
    logic [2*XLEN-1:0]   prod_fix;

    // op[1] selects divide, op[0] selects the unsigned variant
    assign is_div     = op_q[1];
    assign is_signed  = ~op_q[0];
    assign abs_a      = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
    assign abs_b      = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff   = div_rem_sh - {1'b0, opnd_q};
    assign prod_fix   = neg_quo_q ? -acc_q : acc_q;
    assign quo        = acc_q[XLEN-1:0];
    assign rem        = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = S_PREP;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_PREP: begin
                neg_quo_d = is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                neg_rem_d = is_signed & a_q[XLEN-1];
                if (is_div) begin
                    opnd_d = abs_b;
                    acc_d  = {{XLEN{1'b0}}, abs_a};
                end else begin
                    opnd_d = abs_a;
                    acc_d  = {{XLEN{1'b0}}, abs_b};
                end
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (is_div) begin
                    if (!div_diff[XLEN])
                        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div) begin
                    // divide by zero returns the raw dividend, no sign fix-up
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = neg_quo_q ? -quo : quo;
                        hi_d = neg_rem_q ? -rem : rem;
                    end
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (start | mfhi | mflo | mthi | mtlo);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = mfhi ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] op_a = '0, op_b = '0, wdata = '0;
    logic        mfhi = 1'b0, mflo = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic        busy, stall, done;
    logic [31:0] hi, lo, rdata;

    int total = 0;
    int bad = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (!o[1]) begin
            if (o[0]) p = {32'b0, a} * {32'b0, b};
            else      p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            l = 32'hFFFFFFFF;
            h = a;
        end else if (o[0]) begin
            l = a / b;
            h = a % b;
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mflo_from, input int restart_at, input string nm);
        logic [31:0] eh, el;
        ref_op(o, a, b, eh, el);
        @(posedge clk); #1;
        op = o; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL %s cycle0 busy/stall: got %b/%b want 0/0", nm, busy, stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            mflo  = (mflo_from > 0 && c >= mflo_from);
            start = (c == restart_at);
            if (start) begin
                op = ~o; op_a = $urandom; op_b = $urandom;
            end
            @(negedge clk);
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL %s busy/done cycle %0d: got %b/%b want 1/0", nm, c, busy, done);
            end
            total++;
            if (stall !== (mflo | start)) begin
                bad++; $display("FAIL %s stall cycle %0d: got %b want %b", nm, c, stall, mflo | start);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL %s cycle35 done/busy/stall: got %b/%b/%b want 1/0/0", nm, done, busy, stall);
        end
        total++;
        if (hi !== eh || lo !== el) begin
            bad++; $display("FAIL %s result op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                            nm, o, a, b, hi, lo, eh, el);
        end
        if (mflo_from > 0) begin
            total++;
            if (rdata !== el) begin
                bad++; $display("FAIL %s rdata: got %h want %h", nm, rdata, el);
            end
        end
        mflo = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mflo = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL reset_state: got busy=%b done=%b stall=%b hi=%h lo=%h want 0", busy, done, stall, hi, lo);
        end
        mflo = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_multu_max;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, "multu_max");
        total++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++; $display("FAIL multu_max_const: got hi=%h lo=%h want fffffffe/00000001", hi, lo);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL done_pulse_width: got %b want 0", done);
        end
    endtask

    task automatic test_mult_signed;
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 0, 0, "mult_neg");
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            bad++; $display("FAIL mult_neg_const: got hi=%h lo=%h want ffffffff/fffffff1", hi, lo);
        end
    endtask

    task automatic test_divide;
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0, 0, "div_neg");
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            bad++; $display("FAIL div_neg_const: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
        end
        run_op(2'b11, 32'd7, 32'd0, 0, 0, "divu_zero");
        total++;
        if (hi !== 32'h00000007 || lo !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL divu_zero_const: got hi=%h lo=%h want 00000007/ffffffff", hi, lo);
        end
        run_op(2'b10, 32'hFFFFFFF0, 32'd0, 0, 0, "div_zero_signed");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, "div_overflow");
        total++;
        if (hi !== 32'h00000000 || lo !== 32'h80000000) begin
            bad++; $display("FAIL div_overflow_const: got hi=%h lo=%h want 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_stall_mflo;
        run_op(2'b01, 32'd6, 32'd7, 10, 0, "stall_mflo");
        total++;
        if (lo !== 32'd42) begin
            bad++; $display("FAIL stall_mflo_const: got lo=%0d want 42", lo);
        end
    endtask

    task automatic test_mthi_mtlo;
        int cyc;
        @(posedge clk); #1;
        mthi = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1;
        mthi = 1'b0; mfhi = 1'b1;
        @(negedge clk);
        total++;
        if (rdata !== 32'h12345678 || stall !== 1'b0) begin
            bad++; $display("FAIL mthi_mfhi: got rdata=%h stall=%b want 12345678/0", rdata, stall);
        end
        mfhi = 1'b0;
        @(posedge clk); #1;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        total++;
        if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin
            bad++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h want cafef00d", hi, lo);
        end
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; op_a = 32'd3; op_b = 32'd5;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        total++;
        if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D || busy !== 1'b1) begin
            bad++; $display("FAIL start_beats_mt: got hi=%h lo=%h busy=%b want cafef00d/cafef00d/1", hi, lo, busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1 || cyc != 34 || hi !== 32'd0 || lo !== 32'd15) begin
            bad++; $display("FAIL start_beats_mt_result: got done=%b wait=%0d hi=%h lo=%h want 1/34/0/f", done, cyc, hi, lo);
        end
    endtask

    task automatic test_busy_start;
        run_op(2'b10, 32'd1000, 32'hFFFFFFFD, 0, 12, "start_while_busy");
    endtask

    task automatic test_back_to_back;
        logic [31:0] eh, el;
        run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 0, 0, "b2b_first");
        ref_op(2'b11, 32'hDEADBEEF, 32'h00001234, eh, el);
        start = 1'b1; op = 2'b11; op_a = 32'hDEADBEEF; op_b = 32'h00001234;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1) begin
                bad++; $display("FAIL b2b busy cycle %0d: got %b want 1", c, busy);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || hi !== eh || lo !== el) begin
            bad++; $display("FAIL b2b_second: got done=%b hi=%h lo=%h want 1/%h/%h", done, hi, lo, eh, el);
        end
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; op_a = 32'hFFFFFFFF; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        mflo = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h done=%b stall=%b want 0", busy, hi, lo, done, stall);
        end
        mflo = 1'b0;
        seen_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        total++;
        if (seen_done) begin
            bad++; $display("FAIL reset_mid_no_done: got a done/busy after reset want none");
        end
        run_op(2'b11, 32'd100, 32'd7, 0, 0, "divu_after_reset");
        total++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            bad++; $display("FAIL divu_after_reset_const: got hi=%0d lo=%0d want 2/14", hi, lo);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [1:0] o;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h80000000;
                default: ;
            endcase
            run_op(o, a, b, 0, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_stall_mflo();
        test_mthi_mtlo();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
